// File: rtl/mport_arbiter.sv
// -----------------------------------------------------------------------------
// mport_arbiter
//
// Shares one memory port between NUM_REQ requesters. Each transaction runs
// through three states:
//   IDLE    - pick a winner among pending requesters and capture its operands
//   BUSY    - drive w_en or r_en to the memory port manager until done
//   RELEASE - one quiet cycle with req_done pulsed so the winner can drop
//             its request before the next arbitration
//
// Handshake: a requester is pending while req_w_en or req_r_en is high and
// keeps its request and operands stable until its req_done pulse. The
// arbiter holds its strobe to the memory port manager until done is seen
// high; done outside BUSY is ignored.
//
// Configuration macro: MPORT_ARB_FIXED_PRIO_EN
//   undefined - round-robin, search starts after the last granted index
//   defined   - fixed priority, lowest pending index wins, no pointer
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_w_en / req_r_en        per-requester write / read request
//   req_write_through          per-requester write-through flag
//   req_addr, req_data_store   per-requester word address and write data
//   req_data_load              read data, valid while req_done is high
//   req_done                   one-hot single-cycle completion pulse
//   w_en, r_en, write_through  strobes to the memory port manager
//   addr, data_store           address / write data to the manager
//   data_load, done            return path from the manager
//   grant_id, busy             current owner, transaction-in-flight flag
//   dbg_state                  FSM state (0 IDLE, 1 BUSY, 2 RELEASE)
// -----------------------------------------------------------------------------
module mport_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_w_en,
    input  logic [NUM_REQ-1:0]            req_r_en,
    input  logic [NUM_REQ-1:0]            req_write_through,
    input  logic [NUM_REQ-1:0][25:2]      req_addr,
    input  logic [NUM_REQ-1:0][31:0]      req_data_store,
    output logic [31:0]                   req_data_load,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          w_en,
    output logic                          r_en,
    output logic                          write_through,
    output logic [25:2]                   addr,
    output logic [31:0]                   data_store,
    input  logic [31:0]                   data_load,
    input  logic                          done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_REQ-1:0] pending;
    logic               any_pending;
    logic [GW-1:0]      winner;

    logic [GW-1:0]      grant_q;
    logic [25:2]        addr_q;
    logic [31:0]        data_q;
    logic               wt_q;
    logic               is_wr_q;
    logic [31:0]        rdata_q;
    logic [NUM_REQ-1:0] done_q;

    assign pending     = req_w_en | req_r_en;
    assign any_pending = |pending;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef MPORT_ARB_FIXED_PRIO_EN
    // Scan from the top so the lowest pending index is the last to write.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                winner = GW'(k);
            end
        end
    end
`else
    logic [GW-1:0] last_q;

    // Search order starts one past the last winner and wraps to index 0.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_v;
        logic          found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(last_q) + 1 + k) % NUM_REQ;
            idx_v = idx[GW-1:0];
            if (!found && pending[idx_v]) begin
                winner = idx_v;
                found  = 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_pending) state_d = ST_BUSY;
            ST_BUSY:    if (done)        state_d = ST_RELEASE;
            ST_RELEASE:                  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wt_q    <= 1'b0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= '0;
`ifndef MPORT_ARB_FIXED_PRIO_EN
            // Pointing at the top index makes index 0 the first searched.
            last_q  <= GW'(NUM_REQ - 1);
`endif
        end else begin
            done_q <= '0;
            if (state_q == ST_IDLE && any_pending) begin
                grant_q <= winner;
                addr_q  <= req_addr[winner];
                data_q  <= req_data_store[winner];
                wt_q    <= req_write_through[winner];
                // Write wins when both request bits are set.
                is_wr_q <= req_w_en[winner];
`ifndef MPORT_ARB_FIXED_PRIO_EN
                last_q  <= winner;
`endif
            end
            if (state_q == ST_BUSY && done) begin
                rdata_q <= data_load;
                done_q  <= NUM_REQ'(1) << grant_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_en          = (state_q == ST_BUSY) &&  is_wr_q;
        r_en          = (state_q == ST_BUSY) && !is_wr_q;
        busy          = (state_q != ST_IDLE);
        write_through = wt_q;
        addr          = addr_q;
        data_store    = data_q;
        grant_id      = grant_q;
        req_done      = done_q;
        req_data_load = rdata_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_mport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mport_arbiter
//
// Directed scenarios followed by a randomized stream of transactions. The
// expected winner comes from a small model of the arbitration rule kept in
// this file; the memory port manager is emulated by the serve task, which
// answers each strobe after a chosen latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mport_arbiter;

    localparam int N  = 4;
    localparam int GW = $clog2(N);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [N-1:0]       req_w_en;
    logic [N-1:0]       req_r_en;
    logic [N-1:0]       req_write_through;
    logic [N-1:0][25:2] req_addr;
    logic [N-1:0][31:0] req_data_store;
    logic [31:0]        req_data_load;
    logic [N-1:0]       req_done;
    logic               w_en;
    logic               r_en;
    logic               write_through;
    logic [25:2]        addr;
    logic [31:0]        data_store;
    logic [31:0]        data_load;
    logic               done;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic [1:0]         dbg_state;

    mport_arbiter #(.NUM_REQ(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_w_en          (req_w_en),
        .req_r_en          (req_r_en),
        .req_write_through (req_write_through),
        .req_addr          (req_addr),
        .req_data_store    (req_data_store),
        .req_data_load     (req_data_load),
        .req_done          (req_done),
        .w_en              (w_en),
        .r_en              (r_en),
        .write_through     (write_through),
        .addr              (addr),
        .data_store        (data_store),
        .data_load         (data_load),
        .done              (done),
        .grant_id          (grant_id),
        .busy              (busy),
        .dbg_state         (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          model_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: first pending index, searching from one past the
    // last winner (round-robin) or from index 0 (fixed priority).
    function automatic int model_pick(input logic [N-1:0] pend, input int last);
        int w;
        int j;
        w = -1;
        for (int k = 0; k < N; k++) begin
`ifdef MPORT_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (last + 1 + k) % N;
`endif
            if (w < 0 && pend[j]) w = j;
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic w, input logic r, input logic wt,
                           input logic [23:0] a, input logic [31:0] d);
        req_w_en[i]          = w;
        req_r_en[i]          = r;
        req_write_through[i] = wt;
        req_addr[i]          = a;
        req_data_store[i]    = d;
    endtask

    task automatic clr_req(input int i);
        req_w_en[i] = 1'b0;
        req_r_en[i] = 1'b0;
    endtask

    task automatic rand_req(input int i);
        int op;
        op = $urandom_range(0, 2);
        set_req(i, op != 1, op != 0, 1'($urandom_range(0, 1)), 24'($urandom), $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_en"},       w_en, 0);
        check({tag, "_r_en"},       r_en, 0);
        check({tag, "_wt"},         write_through, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_req_done"},   req_done, 0);
        check({tag, "_grant_id"},   grant_id, 0);
        check({tag, "_addr"},       addr, 0);
        check({tag, "_data_store"}, data_store, 0);
        check({tag, "_rdata"},      req_data_load, 0);
        check({tag, "_state"},      dbg_state, 0);
    endtask

    // Called at a falling edge while the DUT is IDLE with a request
    // pending. Emulates the memory port manager with 'lat' strobe cycles.
    task automatic serve(input int lat, input logic [31:0] rdata,
                         input bit drop_end, input bit drop_early);
        int          win;
        int          waited;
        bit          seen;
        logic        e_wr;
        logic        e_wt;
        logic [23:0] e_addr;
        logic [31:0] e_data;
        logic [31:0] exp_win;

        win = model_pick(req_w_en | req_r_en, model_last);
        model_last = win;
        exp_q.push_back(32'(win));
        e_wr   = req_w_en[win];
        e_wt   = req_write_through[win];
        e_addr = req_addr[win];
        e_data = req_data_store[win];

        waited = 0;
        seen   = 0;
        while (!seen && waited < 8) begin
            @(negedge clk);
            waited++;
            seen = w_en | r_en;
        end
        check("strobe_latency", waited, 1);
        if (!seen) begin
            void'(exp_q.pop_front());
            return;
        end

        exp_win = exp_q.pop_front();
        check("grant_id",   grant_id, exp_win);
        check("w_en",       w_en, e_wr);
        check("r_en",       r_en, !e_wr);
        check("addr",       addr, e_addr);
        check("busy_on",    busy, 1);
        if (e_wr) check("data_store", data_store, e_data);
        if (e_wr) check("write_through", write_through, e_wt);

        if (drop_early) clr_req(win);

        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(negedge clk);
                check("hold_w_en", w_en, e_wr);
                check("hold_r_en", r_en, !e_wr);
                check("no_early_done", req_done, 0);
            end
            if (c == lat) begin
                done      = 1'b1;
                data_load = rdata;
            end
        end

        @(negedge clk);
        done      = 1'b0;
        data_load = ~rdata;
        check("release_strobes", {w_en, r_en}, 0);
        check("req_done_pulse",  req_done, 32'(1) << win);
        check("req_data_load",   req_data_load, rdata);
        check("busy_release",    busy, 1);
        if (drop_end) clr_req(win);

        @(negedge clk);
        check("done_single",  req_done, 0);
        check("busy_idle",    busy, 0);
        check("idle_strobes", {w_en, r_en}, 0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int win;

        rst               = 1'b1;
        req_w_en          = '0;
        req_r_en          = '0;
        req_write_through = '0;
        req_addr          = '0;
        req_data_store    = '0;
        data_load         = '0;
        done              = 1'b0;
        model_last        = N - 1;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Spurious done while IDLE
        done      = 1'b1;
        data_load = 32'hCAFE_F00D;
        @(negedge clk);
        done = 1'b0;
        check("spur_req_done", req_done, 0);
        check("spur_busy",     busy, 0);
        check("spur_state",    dbg_state, 0);
        check("spur_rdata",    req_data_load, 0);
        @(negedge clk);
        check("spur_req_done2", req_done, 0);
        check("spur_strobes",   {w_en, r_en}, 0);

        // All four requesters hold writes: 0,1,2,3,0 in round-robin
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 1'b0, 1'(i & 1), 24'h100 + 24'(i), 32'hA000_0000 + 32'(i));
        end
`ifndef MPORT_ARB_FIXED_PRIO_EN
        for (int t = 0; t < 5; t++) begin
            check("rr_order_model", model_pick(req_w_en | req_r_en, model_last), t % N);
            serve(2, 32'h0, 0, 0);
        end
`else
        for (int t = 0; t < 5; t++) serve(2, 32'h0, 0, 0);
`endif
        for (int i = 0; i < N; i++) clr_req(i);

        // Single read by requester 2, five-cycle memory latency
        set_req(2, 1'b0, 1'b1, 1'b0, 24'h000010, 32'h0);
        serve(5, 32'hDEAD_BEEF, 1, 0);

        // Both strobes from requester 1: write only
        set_req(1, 1'b1, 1'b1, 1'b0, 24'h000444, 32'h1234_5678);
        serve(3, 32'h5555_AAAA, 1, 0);

`ifdef MPORT_ARB_FIXED_PRIO_EN
        // Requesters 0 and 3 continuously pending: 0 always wins
        set_req(0, 1'b1, 1'b0, 1'b0, 24'h000AAA, 32'h0000_0A0A);
        set_req(3, 1'b1, 1'b0, 1'b0, 24'h000BBB, 32'h0000_0B0B);
        for (int t = 0; t < 4; t++) serve(2, 32'h0, 0, 0);
        clr_req(0);
        clr_req(3);
`endif

        // Reset during BUSY: transaction abandoned, index 0 searched first
        set_req(0, 1'b0, 1'b1, 1'b0, 24'h000020, 32'h0);
        set_req(1, 1'b0, 1'b1, 1'b0, 24'h000021, 32'h0);
        set_req(2, 1'b0, 1'b1, 1'b0, 24'h000022, 32'h0);
        win = model_pick(req_w_en | req_r_en, model_last);
        @(negedge clk);
        check("pre_rst_grant", grant_id, win);
        check("pre_rst_r_en",  r_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_busy_rst");
        model_last = N - 1;
        for (int t = 0; t < 3; t++) serve($urandom_range(1, 4), $urandom, 1, 0);

        // Request dropped during BUSY still completes
        set_req(3, 1'b0, 1'b1, 1'b0, 24'h000333, 32'h0);
        serve(4, 32'h0BAD_CAFE, 0, 1);

        // Randomized stream
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_w_en[i] | req_r_en[i]) && $urandom_range(0, 1) == 1) rand_req(i);
            end
            if ((req_w_en | req_r_en) == '0) rand_req($urandom_range(0, N - 1));
            serve($urandom_range(1, 6), $urandom, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
